// File: rtl/blink_pkg.sv
// Shared definitions for the blink rate detector: default half-periods (in
// 25 kHz clock cycles), the matching tolerance shift, rate-code and FSM
// state encodings, and the tolerance-window helper.
package blink_pkg;

    localparam int unsigned CntW         = 16;
    localparam int unsigned DefCnt100Hz  = 125;
    localparam int unsigned DefCnt50Hz   = 250;
    localparam int unsigned DefCnt10Hz   = 1250;
    localparam int unsigned DefCnt1Hz    = 12500;
    localparam int unsigned DefTimeout   = 25000;
    // Window is nominal +/- nominal/8.
    localparam int unsigned TolShift     = 3;

    typedef enum logic [1:0] {
        Rate100Hz = 2'b00,
        Rate50Hz  = 2'b01,
        Rate10Hz  = 2'b10,
        Rate1Hz   = 2'b11
    } rate_code_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAcquire = 2'b01,
        StConfirm = 2'b10,
        StLocked  = 2'b11
    } state_e;

    // True when a captured half-period count falls inside the window of nom.
    function automatic logic in_window(input logic [CntW-1:0] n, input int unsigned nom);
        int unsigned tol;
        tol = nom >> TolShift;
        return (32'(n) >= (nom - tol)) && (32'(n) <= (nom + tol));
    endfunction

endpackage

// File: rtl/blink_input_sync.sv
// Input conditioning for the blink rate detector.
//   i_clock   : 25 kHz clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   i_led_in  : asynchronous blink waveform
//   o_level   : synchronized (optionally filtered) level
//   o_edge    : high for the cycle in which o_level differs from its previous value
// Macro BLINK_DET_GLITCH_FILTER_EN adds a 3-sample majority filter after the
// synchronizer (2 extra cycles of latency, single-cycle glitches removed).
module blink_input_sync (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_led_in,
    output logic o_level,
    output logic o_edge
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_prev_q, level_prev_d;
    logic level;

    always_comb begin
        sync1_d      = i_led_in;
        sync2_d      = sync1_q;
        level_prev_d = level;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_prev_q <= level_prev_d;
        end
    end

`ifdef BLINK_DET_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;

    // Majority of the current and two previous synchronized samples.
    always_comb begin
        hist_d = {hist_q[0], sync2_q};
        filt_d = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign o_level = level;
    assign o_edge  = level ^ level_prev_q;

endmodule

// File: rtl/blink_rate_detector.sv
// Classifies a blink waveform as 100/50/10/1 Hz by measuring half-periods.
//   i_clock     : 25 kHz clock, rising edge
//   i_reset_n   : asynchronous active-low reset
//   i_led_in    : asynchronous blink waveform
//   o_rate_code : 11=1 Hz, 10=10 Hz, 01=50 Hz, 00=100 Hz (meaningful while o_valid)
//   o_valid     : high while locked
//   o_change    : one-cycle pulse when a lock is first established or its code changes
//   o_level     : conditioned copy of i_led_in
// Macro BLINK_DET_GLITCH_FILTER_EN enables the majority glitch filter in blink_input_sync.
module blink_rate_detector
    import blink_pkg::*;
#(
    parameter int unsigned c_CNT_100HZ = DefCnt100Hz,
    parameter int unsigned c_CNT_50HZ  = DefCnt50Hz,
    parameter int unsigned c_CNT_10HZ  = DefCnt10Hz,
    parameter int unsigned c_CNT_1HZ   = DefCnt1Hz,
    parameter int unsigned c_TIMEOUT   = DefTimeout
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_led_in,
    output logic [1:0] o_rate_code,
    output logic       o_valid,
    output logic       o_change,
    output logic       o_level
);

    logic            edge_det;
    logic [CntW-1:0] cnt_q, cnt_d;
    state_e          state_q, state_d;
    rate_code_e      cand_q, cand_d;
    rate_code_e      code_q, code_d;
    logic            valid_q, valid_d;
    logic            change_q, change_d;
    logic            have_lock_q, have_lock_d;
    logic            match;
    rate_code_e      match_code;
    logic            timeout;
    logic            enter_lock;

    blink_input_sync u_input_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_led_in  (i_led_in),
        .o_level   (o_level),
        .o_edge    (edge_det)
    );

    // Half-period counter: restarts at 1 after an edge, saturates at all-ones.
    always_comb begin
        if (edge_det) begin
            cnt_d = CntW'(1);
        end else if (cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The windows do not overlap, so priority order is irrelevant.
    always_comb begin
        match      = 1'b0;
        match_code = Rate100Hz;
        if (in_window(cnt_q, c_CNT_100HZ)) begin
            match      = 1'b1;
            match_code = Rate100Hz;
        end else if (in_window(cnt_q, c_CNT_50HZ)) begin
            match      = 1'b1;
            match_code = Rate50Hz;
        end else if (in_window(cnt_q, c_CNT_10HZ)) begin
            match      = 1'b1;
            match_code = Rate10Hz;
        end else if (in_window(cnt_q, c_CNT_1HZ)) begin
            match      = 1'b1;
            match_code = Rate1Hz;
        end
    end

    // An edge on the same cycle pre-empts the timeout.
    assign timeout = !edge_det && (32'(cnt_q) >= c_TIMEOUT);

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        unique case (state_q)
            StIdle: begin
                // First edge only starts timing.
                if (edge_det) state_d = StAcquire;
            end
            StAcquire: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (edge_det && match) begin
                    state_d = StConfirm;
                    cand_d  = match_code;
                end
            end
            StConfirm: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (edge_det) begin
                    if (!match) begin
                        state_d = StAcquire;
                    end else if (match_code == cand_q) begin
                        state_d = StLocked;
                    end else begin
                        cand_d = match_code;
                    end
                end
            end
            StLocked: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (edge_det) begin
                    if (!match) begin
                        state_d = StAcquire;
                    end else if (match_code != code_q) begin
                        state_d = StConfirm;
                        cand_d  = match_code;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic (registered below)
    always_comb begin
        enter_lock  = (state_q != StLocked) && (state_d == StLocked);
        valid_d     = (state_d == StLocked);
        code_d      = enter_lock ? cand_q : code_q;
        change_d    = enter_lock && (!have_lock_q || (cand_q != code_q));
        // have_lock remembers a lock since the last reset/IDLE visit.
        have_lock_d = (state_d == StIdle) ? 1'b0 : (have_lock_q | enter_lock);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q       <= '0;
            cand_q      <= Rate100Hz;
            code_q      <= Rate100Hz;
            valid_q     <= 1'b0;
            change_q    <= 1'b0;
            have_lock_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            change_q    <= change_d;
            have_lock_q <= have_lock_d;
        end
    end

    assign o_rate_code = code_q;
    assign o_valid     = valid_q;
    assign o_change    = change_q;

endmodule

// File: tb/tb_blink_rate_detector.sv
module tb_blink_rate_detector;

    localparam int NOM [4] = '{125, 250, 1250, 12500};  // index == rate code
    localparam int TIMEOUT = 25000;

    logic       clk;
    logic       rst_n;
    logic       led;
    logic [1:0] rate_code;
    logic       valid;
    logic       change;
    logic       level;

    blink_rate_detector dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_led_in    (led),
        .o_rate_code (rate_code),
        .o_valid     (valid),
        .o_change    (change),
        .o_level     (level)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] c;
        logic       ch;
    } ev_t;
    ev_t exp_q[$];

    // Reference model: locked iff the last two classified edges name the same rate.
    bit active;
    bit locked;
    bit first;
    int prev_class;
    int code_m;
    int last_toggle;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int classify(input int n);
        for (int r = 0; r < 4; r++) begin
            int tol;
            tol = NOM[r] / 8;
            if (n >= NOM[r] - tol && n <= NOM[r] + tol) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        active = 0; locked = 0; first = 1; prev_class = -1; code_m = 0;
    endtask

    task automatic model_edge(input int n);
        int  c;
        bit  lk;
        if (!active) begin
            active = 1; first = 1; prev_class = -1;
            return;
        end
        c  = classify(n);
        lk = (c >= 0) && (c == prev_class);
        if (lk && !locked) begin
            exp_q.push_back('{v: 1'b1, c: 2'(c), ch: (first || c != code_m)});
            code_m = c;
            first  = 0;
        end else if (!lk && locked) begin
            exp_q.push_back('{v: 1'b0, c: 2'(code_m), ch: 1'b0});
        end
        locked     = lk;
        prev_class = c;
    endtask

    task automatic hold(input int k);
        if (active && (cyc + k - last_toggle) > TIMEOUT) begin
            if (locked) exp_q.push_back('{v: 1'b0, c: 2'(code_m), ch: 1'b0});
            locked = 0;
            active = 0;
        end
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic toggle_led();
        led = ~led;
        model_edge(cyc - last_toggle);
        last_toggle = cyc;
    endtask

    task automatic half(input int p);
        hold(p);
        toggle_led();
    endtask

    // One-cycle blip on the input.
    task automatic glitch_led();
`ifdef BLINK_DET_GLITCH_FILTER_EN
        led = ~led;
        @(posedge clk); #1;
        led = ~led;
`else
        toggle_led();
        @(posedge clk); #1;
        toggle_led();
`endif
    endtask

    function automatic int pick_p(input int ri);
        int tol, lo, hi, k;
        tol = NOM[ri] / 8;
        lo  = NOM[ri] - tol;
        hi  = NOM[ri] + tol;
        k   = int'($urandom_range(0, 9));
        case (k)
            0:       return lo - 1 - int'($urandom_range(0, 5));
            1:       return hi + 1 + int'($urandom_range(0, 5));
            2:       return lo;
            3:       return hi;
            default: return int'($urandom_range(lo, hi));
        endcase
    endfunction

    task automatic expect_state(input string name, input int v, input int c);
        check({name, "_valid"}, int'(valid), v);
        check({name, "_code"}, int'(rate_code), c);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, int'(valid), 0);
        check({name, "_code"}, int'(rate_code), 0);
        check({name, "_change"}, int'(change), 0);
        check({name, "_level"}, int'(level), 0);
    endtask

    // Monitor: each output event is popped from the scoreboard and compared;
    // also checks o_level against the delayed input.
    initial begin
        logic       prev_v;
        logic [1:0] prev_c;
        logic       led_hist [8];
        int         rst_cnt;
        ev_t        e;
        int         want_lvl;
        prev_v = 1'b0; prev_c = 2'b00; rst_cnt = 0;
        for (int i = 0; i < 8; i++) led_hist[i] = 1'b0;
        forever begin
            @(negedge clk);
            led_hist[cyc & 7] = led;
            if (!rst_n) begin
                prev_v  = 1'b0;
                prev_c  = 2'b00;
                rst_cnt = 0;
            end else begin
                rst_cnt++;
                if (valid !== prev_v || rate_code !== prev_c || change !== 1'b0) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_event: got v=%0b c=%0d ch=%0b, want none (cycle %0d)",
                                 valid, rate_code, change, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_valid", int'(valid), int'(e.v));
                        check("event_code", int'(rate_code), int'(e.c));
                        check("event_change", int'(change), int'(e.ch));
                    end
                    prev_v = valid;
                    prev_c = rate_code;
                end
                if (rst_cnt > 8) begin
`ifdef BLINK_DET_GLITCH_FILTER_EN
                    want_lvl = (int'(led_hist[(cyc - 3) & 7]) + int'(led_hist[(cyc - 4) & 7])
                                + int'(led_hist[(cyc - 5) & 7])) >= 2 ? 1 : 0;
`else
                    want_lvl = int'(led_hist[(cyc - 2) & 7]);
`endif
                    if (int'(level) != want_lvl) check("level", int'(level), want_lvl);
                    else n_tests++;
                end
            end
        end
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ri, run, r;
        rst_n = 1'b0;
        led   = 1'b0;
        model_reset();
        last_toggle = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 100 Hz square wave: locks on the 3rd edge.
        half(125); half(125);
        hold(10);
        check("lock100_not_yet", int'(valid), 0);
        hold(115); toggle_led();
        hold(10);
        expect_state("lock100", 1, 0);

        // 141 is just outside the 100 Hz window.
        repeat (4) half(141);
        hold(10);
        expect_state("out_of_window", 0, 0);

        // Randomized half-periods around the windows.
        for (int i = 0; i < 7; i++) begin
            r   = int'($urandom_range(0, 7));
            ri  = (r < 3) ? 0 : (r < 6) ? 1 : 2;
            run = int'($urandom_range(1, 4));
            for (int j = 0; j < run; j++) half(pick_p(ri));
        end
        hold(20);
        check("random_queue_empty", exp_q.size(), 0);

        // Lock at 50 Hz, then starve the input until timeout.
        repeat (3) half(250);
        hold(10);
        expect_state("lock50", 1, 1);
        hold(25010);
        expect_state("timeout", 0, 1);

        // From IDLE: lock at 1 Hz, then move to 10 Hz.
        toggle_led();
        half(12500); half(12500);
        hold(10);
        expect_state("lock1", 1, 3);
        half(1250);
        hold(10);
        expect_state("switch_drop", 0, 3);
        half(1250);
        hold(10);
        expect_state("relock10", 1, 2);

        // Glitch inside a locked 50 Hz wave.
        repeat (3) half(250);
        hold(10);
        expect_state("lock50_again", 1, 1);
        hold(90);
        glitch_led();
        half(149);
        hold(10);
`ifdef BLINK_DET_GLITCH_FILTER_EN
        expect_state("glitch", 1, 1);
`else
        expect_state("glitch", 0, 1);
`endif
        half(240); half(250);
        hold(10);
        expect_state("after_glitch", 1, 1);

        // Reset in the middle of CONFIRM.
        half(240);
        hold(115);
        toggle_led();
        hold(20);
        check("confirm_valid", int'(valid), 0);
        check("pre_reset_queue_empty", exp_q.size(), 0);
        rst_n = 1'b0;
        led   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        half(125); half(125);
        hold(10);
        check("post_reset_two_edges", int'(valid), 0);
        hold(115); toggle_led();
        hold(10);
        expect_state("post_reset_lock", 1, 0);

        hold(20);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
